// File: rtl/inst_sram_bridge.sv
// Instruction-side SRAM-like bus bridge for the IF stage: one outstanding fetch,
// misaligned-address detection and discard of responses that belong to flushed fetches.
module inst_sram_bridge #(
  parameter int KSEG_MAP = 1,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      pc,
  input  logic             pc_valid,
  input  logic             flush,
  output logic [31:0]      if_inst,
  output logic             inst_stall,
  output logic             iadee,
  output logic [31:0]      bad_vaddr,
  output logic             inst_req,
  output logic [31:0]      inst_addr,
  input  logic             inst_addr_ok,
  input  logic [31:0]      inst_rdata,
  input  logic             inst_data_ok,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DISCARD} state_t;

  state_t      state, state_nxt;
  logic [31:0] addr_q;
  logic [31:0] held_q;
  logic        flush_seen;
  logic        issue;
  logic        misaligned;
  logic        deliver;

  function automatic logic [31:0] map_addr(input logic [31:0] a);
    if (KSEG_MAP != 0 && a[31:30] == 2'b10)
      return {3'b000, a[28:0]};
    return a;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (&c)
      return c;
    return c + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // Qualifying with reset keeps the bus quiet while reset is held, not just after the next edge.
  assign issue      = reset && (state == IDLE) && pc_valid && (pc[1:0] == 2'b00) && !flush;
  assign misaligned = reset && (state == IDLE) && pc_valid && (pc[1:0] != 2'b00);
  assign deliver    = (state == WAIT) && inst_data_ok && !flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (issue) state_nxt = inst_addr_ok ? WAIT : REQ;
      REQ:     if (inst_addr_ok) state_nxt = (flush_seen || flush) ? DISCARD : WAIT;
      WAIT: begin
        if (inst_data_ok)
          state_nxt = IDLE;
        else if (flush)
          state_nxt = DISCARD;
      end
      DISCARD: if (inst_data_ok) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    inst_req   = 1'b0;
    inst_addr  = addr_q;
    inst_stall = 1'b0;
    if_inst    = held_q;
    iadee      = 1'b0;
    case (state)
      IDLE: begin
        if (issue) begin
          inst_req   = 1'b1;
          inst_addr  = map_addr(pc);
          inst_stall = 1'b1;
        end else if (misaligned) begin
          iadee   = 1'b1;
          if_inst = 32'h0;
        end
      end
      REQ: begin
        inst_req   = 1'b1;
        inst_stall = 1'b1;
      end
      WAIT: begin
        inst_stall = !inst_data_ok;
        if (inst_data_ok)
          if_inst = flush ? 32'h0 : inst_rdata;
      end
      DISCARD: inst_stall = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q       <= 32'h0;
      held_q       <= 32'h0;
      bad_vaddr    <= 32'h0;
      flush_seen   <= 1'b0;
      stall_cycles <= '0;
    end else begin
      if (issue)
        addr_q <= map_addr(pc);
      if (misaligned)
        bad_vaddr <= pc;
      if (deliver)
        held_q <= inst_rdata;
      // A flush while the request is still unaccepted must still kill its response later.
      if (state == REQ)
        flush_seen <= inst_addr_ok ? 1'b0 : (flush_seen | flush);
      else
        flush_seen <= 1'b0;
      if (inst_stall)
        stall_cycles <= sat_inc(stall_cycles);
    end
  end

endmodule

// File: tb/tb_inst_sram_bridge.sv
// Directed bench for inst_sram_bridge: the bench plays the bus slave and queues the words
// that IF must receive, popping them on the data_ok cycles that should deliver.
module tb_inst_sram_bridge;

  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic [31:0]      pc;
  logic             pc_valid;
  logic             flush;
  logic [31:0]      if_inst;
  logic             inst_stall;
  logic             iadee;
  logic [31:0]      bad_vaddr;
  logic             inst_req;
  logic [31:0]      inst_addr;
  logic             inst_addr_ok;
  logic [31:0]      inst_rdata;
  logic             inst_data_ok;
  logic [CNT_W-1:0] stall_cycles;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  inst_sram_bridge #(.KSEG_MAP(1), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .pc(pc), .pc_valid(pc_valid), .flush(flush),
    .if_inst(if_inst), .inst_stall(inst_stall), .iadee(iadee), .bad_vaddr(bad_vaddr),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_rdata(inst_rdata), .inst_data_ok(inst_data_ok), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_pop(input string tag);
    logic [31:0] e;
    total++;
    assert (exp_q.size() != 0) else begin
      bad++;
      $error("FAIL %s observed=%h expected=<queued word>", tag, if_inst);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      total++;
      assert (if_inst === e) else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", tag, if_inst, e);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_bus();
    pc_valid     = 1'b0;
    flush        = 1'b0;
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    inst_rdata   = 32'h0;
  endtask

  task automatic do_reset();
    idle_bus();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    pc    = 32'hBFC0_0000;
    idle_bus();
    pc_valid = 1'b1;
    tick();
    settle();
    chk("rst_req",    inst_req,     32'h0);
    chk("rst_addr",   inst_addr,    32'h0);
    chk("rst_stall",  inst_stall,   32'h0);
    chk("rst_inst",   if_inst,      32'h0);
    chk("rst_bva",    bad_vaddr,    32'h0);
    chk("rst_cnt",    stall_cycles, 32'h0);
    do_reset();

    // 1: single-cycle accept, data next cycle
    pc = 32'hBFC0_0000; pc_valid = 1'b1; inst_addr_ok = 1'b1;
    settle();
    chk("t1_req",   inst_req,   32'h1);
    chk("t1_addr",  inst_addr,  32'h1FC0_0000);
    chk("t1_stall", inst_stall, 32'h1);
    tick();
    inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h3C1D_BFC0;
    exp_q.push_back(32'h3C1D_BFC0);
    settle();
    chk("t1_dstall", inst_stall, 32'h0);
    chk("t1_dreq",   inst_req,   32'h0);
    chk_pop("t1_inst");
    tick();
    idle_bus();
    settle();
    chk("t1_held", if_inst,      32'h3C1D_BFC0);
    chk("t1_cnt",  stall_cycles, 32'h1);

    // 2: addr_ok withheld three cycles; pc changes to prove the address is latched
    do_reset();
    pc = 32'hBFC0_0010; pc_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      inst_addr_ok = (i == 3);
      settle();
      chk($sformatf("t2_req%0d", i),   inst_req,   32'h1);
      chk($sformatf("t2_addr%0d", i),  inst_addr,  32'h1FC0_0010);
      chk($sformatf("t2_stall%0d", i), inst_stall, 32'h1);
      tick();
      pc = 32'h0000_0000;
    end
    inst_addr_ok = 1'b0; pc_valid = 1'b0;
    settle();
    chk("t2_wstall", inst_stall, 32'h1);
    chk("t2_wreq",   inst_req,   32'h0);
    tick();
    inst_data_ok = 1'b1; inst_rdata = 32'h1111_2222;
    exp_q.push_back(32'h1111_2222);
    settle();
    chk("t2_dstall", inst_stall, 32'h0);
    chk_pop("t2_inst");
    tick();
    idle_bus();
    settle();
    chk("t2_cnt", stall_cycles, 32'h5);

    // 3: misaligned fetch
    pc = 32'hBFC0_0002; pc_valid = 1'b1;
    settle();
    chk("t3_iadee", iadee,      32'h1);
    chk("t3_req",   inst_req,   32'h0);
    chk("t3_stall", inst_stall, 32'h0);
    chk("t3_inst",  if_inst,    32'h0);
    tick();
    pc_valid = 1'b0;
    settle();
    chk("t3_bva",    bad_vaddr, 32'hBFC0_0002);
    chk("t3_iadee0", iadee,     32'h0);
    chk("t3_held",   if_inst,   32'h1111_2222);
    chk("t3_cnt",    stall_cycles, 32'h5);

    // 4: flush in WAIT, late response dropped, redirected pc issues afterwards
    pc = 32'h8000_1000; pc_valid = 1'b1; inst_addr_ok = 1'b1;
    settle();
    chk("t4_addr", inst_addr, 32'h0000_1000);
    tick();
    inst_addr_ok = 1'b0; flush = 1'b1;
    settle();
    chk("t4_fstall", inst_stall, 32'h1);
    tick();
    flush = 1'b0; pc = 32'h8000_2000;
    settle();
    chk("t4_dstall", inst_stall, 32'h1);
    chk("t4_dreq",   inst_req,   32'h0);
    tick();
    inst_data_ok = 1'b1; inst_rdata = 32'hDEAD_BEEF;
    settle();
    chk("t4_okstall", inst_stall, 32'h1);
    chk("t4_okinst",  if_inst,    32'h1111_2222);
    tick();
    inst_data_ok = 1'b0;
    settle();
    chk("t4_nreq",  inst_req,  32'h1);
    chk("t4_naddr", inst_addr, 32'h0000_2000);
    chk("t4_held",  if_inst,   32'h1111_2222);
    inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h5555_6666;
    exp_q.push_back(32'h5555_6666);
    settle();
    chk_pop("t4_inst");
    tick();
    idle_bus();

    // 5: flush in REQ before accept, then flush coincident with data_ok
    pc = 32'h8000_3000; pc_valid = 1'b1;
    tick();
    flush = 1'b1;
    settle();
    chk("t5_rreq",   inst_req,   32'h1);
    chk("t5_rstall", inst_stall, 32'h1);
    tick();
    flush = 1'b0; pc = 32'h8000_4000; inst_addr_ok = 1'b1;
    settle();
    chk("t5_hreq",  inst_req,  32'h1);
    chk("t5_haddr", inst_addr, 32'h0000_3000);
    tick();
    inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'hDEAD_BEEF;
    settle();
    chk("t5_dstall", inst_stall, 32'h1);
    chk("t5_dinst",  if_inst,    32'h5555_6666);
    tick();
    inst_data_ok = 1'b0; inst_addr_ok = 1'b1;
    settle();
    chk("t5_nreq",  inst_req,  32'h1);
    chk("t5_naddr", inst_addr, 32'h0000_4000);
    tick();
    inst_addr_ok = 1'b0; pc_valid = 1'b0;
    inst_data_ok = 1'b1; flush = 1'b1; inst_rdata = 32'h7777_8888;
    settle();
    chk("t5_finst",  if_inst,    32'h0);
    chk("t5_fstall", inst_stall, 32'h0);
    tick();
    idle_bus();
    settle();
    chk("t5_held", if_inst,  32'h5555_6666);
    chk("t5_idle", inst_req, 32'h0);

    // counter saturation at all-ones
    do_reset();
    pc = 32'h8000_5000; pc_valid = 1'b1;
    for (int i = 0; i < 9; i++) tick();
    settle();
    chk("sat_cnt", stall_cycles, 32'h7);
    chk("sat_req", inst_req,     32'h1);
    do_reset();

    // 6: asynchronous reset mid-WAIT
    pc = 32'h8000_5000; pc_valid = 1'b1; inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0;
    settle();
    chk("t6_wstall", inst_stall, 32'h1);
    reset = 1'b0;
    #1;
    chk("t6_req",   inst_req,     32'h0);
    chk("t6_inst",  if_inst,      32'h0);
    chk("t6_cnt",   stall_cycles, 32'h0);
    chk("t6_stall", inst_stall,   32'h0);
    tick();
    reset = 1'b1;
    settle();
    chk("t6_ireq",  inst_req,  32'h1);
    chk("t6_iaddr", inst_addr, 32'h0000_5000);
    pc_valid = 1'b0;
    tick();
    settle();
    chk("t6_idle", inst_req, 32'h0);
    chk("t6_q",    exp_q.size(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
